// File: rtl/serial_deserializer_pkg.sv
// rtl/serial_deserializer_pkg.sv - shared frame sizing helpers and state type for the serial link
package serial_deserializer_pkg;

    // Bits on the wire per frame: data bits plus an optional even-parity bit.
    function automatic int frame_len(input int width, input int parity);
        return width + ((parity != 0) ? 1 : 0);
    endfunction

    // Counter width able to hold 0..frame_len inclusive.
    function automatic int cnt_width(input int width, input int parity);
        return $clog2(frame_len(width, parity) + 1);
    endfunction

    typedef enum logic {
        ST_SHIFTING = 1'b0,
        ST_FULL     = 1'b1
    } deser_state_e;

endpackage

// File: rtl/serial_deserializer_if.sv
// rtl/serial_deserializer_if.sv - serial input, parallel output and status signals of the deserializer
//
// Signals:
//   sdata/svalid/sready : one serial bit per accepted strobe
//   sync                : frame realign request
//   q/qvalid/qready     : received word with valid/ready handshake
//   perr                : parity error of the word on q
//   ovf                 : sticky overflow flag
// Modports: slave = deserializer side, master = source/consumer side.
interface serial_deserializer_if #(
    parameter int WIDTH = 8
) ();
    logic             sdata;
    logic             svalid;
    logic             sready;
    logic             sync;
    logic [WIDTH-1:0] q;
    logic             qvalid;
    logic             qready;
    logic             perr;
    logic             ovf;

    modport slave (
        input  sdata, svalid, sync, qready,
        output sready, q, qvalid, perr, ovf
    );

    modport master (
        output sdata, svalid, sync, qready,
        input  sready, q, qvalid, perr, ovf
    );
endinterface

// File: rtl/serial_deserializer_out_reg.sv
// rtl/serial_deserializer_out_reg.sv - single-entry valid/ready holding register (deser_out_reg)
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load, i_data : write request and payload (taken only when o_free)
//   i_ready        : downstream consumes the held entry
//   o_free         : entry empty or being consumed this cycle
//   o_valid,o_data : held entry
module deser_out_reg #(
    parameter int DW = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_free,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_take;

    // A read and a refill may happen in the same cycle.
    assign o_free  = !r_valid || i_ready;
    assign w_take  = i_load && o_free;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            // Data holds its last value after being read.
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - MSB-first bit-serial to parallel word receiver with optional even parity
//
// Ports:
//   i_clk   : clock, all logic on rising edge
//   i_reset : synchronous active-high reset
//   s_if    : serial_deserializer_if.slave (sdata/svalid/sready/sync in, q/qvalid/qready/perr/ovf out)
// Parameters:
//   WIDTH  : data bits per frame (>= 2)
//   PARITY : 1 adds one even-parity bit after the data bits
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PARITY = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    serial_deserializer_if.slave  s_if
);
    localparam int FRAME = frame_len(WIDTH, PARITY);
    localparam int CNT_W = cnt_width(WIDTH, PARITY);
    localparam logic [CNT_W-1:0] C_FRAME = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    deser_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_base;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic             r_par, w_par_nxt, w_par_base;
    logic             r_ovf;

    logic             w_sready;
    logic             w_accept;
    logic             w_out_free;
    logic             w_xfer;
    logic             w_perr_pending;
    logic [WIDTH:0]   w_out_data;
    logic             w_out_valid;

    // Ready is low exactly while a complete frame waits for the output stage.
    assign w_sready = (r_cnt < C_FRAME);
    assign w_accept = s_if.svalid && w_sready;
    assign w_xfer   = (r_state == ST_FULL) && w_out_free;

    // Without parity the running XOR is meaningless, so no error is reported.
    assign w_perr_pending = (PARITY != 0) ? r_par : 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_SHIFTING;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            r_par   <= w_par_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_par_nxt   = r_par;
        w_cnt_base  = r_cnt;
        w_par_base  = r_par;
        case (r_state)
            ST_SHIFTING: begin
                // SYNC restarts the frame; a bit accepted alongside it is bit 0.
                w_cnt_base = s_if.sync ? '0 : r_cnt;
                w_par_base = s_if.sync ? 1'b0 : r_par;
                w_cnt_nxt  = w_cnt_base;
                w_par_nxt  = w_par_base;
                if (w_accept) begin
                    // Stale bits from a discarded partial frame shift out before completion.
                    if (w_cnt_base < C_WIDTH) begin
                        w_sh_nxt = {r_sh[WIDTH-2:0], s_if.sdata};
                    end
                    w_par_nxt = w_par_base ^ s_if.sdata;
                    w_cnt_nxt = w_cnt_base + C_ONE;
                    if (w_cnt_base + C_ONE == C_FRAME) begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // SYNC has no effect here; the completed word is kept.
                if (w_xfer) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b0;
                    w_state_nxt = ST_SHIFTING;
                end
            end
            default: begin
                w_state_nxt = ST_SHIFTING;
                w_cnt_nxt   = '0;
                w_par_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf <= 1'b0;
        end else if (s_if.svalid && !w_sready) begin
            r_ovf <= 1'b1;
        end
    end

    deser_out_reg #(
        .DW (WIDTH + 1)
    ) u_out_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_xfer),
        .i_data  ({r_sh, w_perr_pending}),
        .i_ready (s_if.qready),
        .o_free  (w_out_free),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

    assign s_if.sready = w_sready;
    assign s_if.q      = w_out_data[WIDTH:1];
    assign s_if.perr   = w_out_data[0];
    assign s_if.qvalid = w_out_valid;
    assign s_if.ovf    = r_ovf;
endmodule
